// File: rtl/hazard_forward_controller.sv
// rtl/hazard_forward_controller.sv - pipeline hazard detection, flush/stall control and ALU operand forwarding
module hazard_forward_controller #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] decode_rs_address,
  input  logic [ADDR_W-1:0] decode_rt_address,
  input  logic              decode_uses_rs,
  input  logic              decode_uses_rt,
  input  logic [ADDR_W-1:0] execute_rs_address,
  input  logic [ADDR_W-1:0] execute_rt_address,
  input  logic [ADDR_W-1:0] execute_regfile_write_address,
  input  logic              execute_refile_write_en,
  input  logic              execute_ram_to_register_en,
  input  logic              execute_branch_taken,
  input  logic              multdiv_start,
  input  logic              multdiv_ready,
  output logic              pipeline_stall,
  output logic              execute_bubble_en,
  output logic              flush_en,
  output logic [1:0]        forward_a_select,
  output logic [1:0]        forward_b_select,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  localparam logic [1:0] SEL_REGFILE = 2'b00;
  localparam logic [1:0] SEL_MEM     = 2'b01;
  localparam logic [1:0] SEL_WB      = 2'b10;

  state_t state;
  state_t state_next;

  // Shadow copies of the destination fields held by the X/M and M/W latches.
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_write_en;
  logic              mem_load;
  logic [ADDR_W-1:0] wb_addr;
  logic              wb_write_en;

  logic load_use_hazard;
  logic stall_raw;
  logic bubble_raw;
  logic flush_raw;

  function automatic logic [1:0] forward_select(
    input logic [ADDR_W-1:0] src,
    input logic [ADDR_W-1:0] m_addr,
    input logic              m_write_en,
    input logic              m_load,
    input logic [ADDR_W-1:0] w_addr,
    input logic              w_write_en
  );
    logic [1:0] sel;
    sel = SEL_REGFILE;
    if (src != '0) begin
      // A load in memory has no data yet; the stall lets it reach writeback first.
      if (m_write_en && (m_addr == src) && !m_load) begin
        sel = SEL_MEM;
      end else if (w_write_en && (w_addr == src)) begin
        sel = SEL_WB;
      end
    end
    return sel;
  endfunction

  always_comb begin
    load_use_hazard = 1'b0;
    if (execute_ram_to_register_en && execute_refile_write_en &&
        (execute_regfile_write_address != '0)) begin
      load_use_hazard =
        (decode_uses_rs && (decode_rs_address == execute_regfile_write_address)) ||
        (decode_uses_rt && (decode_rt_address == execute_regfile_write_address));
    end
  end

  always_comb begin
    state_next = state;
    stall_raw  = 1'b0;
    bubble_raw = 1'b0;
    flush_raw  = 1'b0;
    case (state)
      RUN: begin
        if (execute_branch_taken) begin
          // The decode instruction is killed, so any load-use match is moot.
          flush_raw  = 1'b1;
          state_next = FLUSH;
        end else begin
          stall_raw  = load_use_hazard;
          bubble_raw = load_use_hazard;
          if (multdiv_start && !multdiv_ready) begin
            state_next = MD_WAIT;
          end
        end
      end
      MD_WAIT: begin
        stall_raw = !multdiv_ready;
        if (multdiv_ready) begin
          state_next = RUN;
        end
      end
      FLUSH: begin
        state_next = RUN;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Reset forces the control outputs low without waiting for a clock edge.
  always_comb begin
    pipeline_stall    = stall_raw  && !reset;
    execute_bubble_en = bubble_raw && !reset;
    flush_en          = flush_raw  && !reset;
    forward_a_select  = 2'b00;
    forward_b_select  = 2'b00;
    if (!reset) begin
      forward_a_select = forward_select(execute_rs_address, mem_addr, mem_write_en,
                                        mem_load, wb_addr, wb_write_en);
      forward_b_select = forward_select(execute_rt_address, mem_addr, mem_write_en,
                                        mem_load, wb_addr, wb_write_en);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_addr     <= '0;
      mem_write_en <= 1'b0;
      mem_load     <= 1'b0;
      wb_addr      <= '0;
      wb_write_en  <= 1'b0;
    end else if (state != MD_WAIT) begin
      mem_addr     <= execute_regfile_write_address;
      mem_write_en <= execute_refile_write_en;
      mem_load     <= execute_ram_to_register_en;
      wb_addr      <= mem_addr;
      wb_write_en  <= mem_write_en;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (pipeline_stall && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (flush_en && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_forward_controller.sv
// tb/tb_hazard_forward_controller.sv - scoreboard bench for hazard_forward_controller
module tb_hazard_forward_controller;

  localparam int AW = 5;
  localparam int CW = 16;

  localparam logic [1:0] ST_RUN = 2'd0;
  localparam logic [1:0] ST_MD  = 2'd1;
  localparam logic [1:0] ST_FL  = 2'd2;

  typedef struct packed {
    logic          rst;
    logic [AW-1:0] d_rs;
    logic [AW-1:0] d_rt;
    logic          u_rs;
    logic          u_rt;
    logic [AW-1:0] x_rs;
    logic [AW-1:0] x_rt;
    logic [AW-1:0] x_dst;
    logic          x_we;
    logic          x_ld;
    logic          br;
    logic          md_start;
    logic          md_ready;
  } stim_t;

  typedef struct packed {
    logic          stall;
    logic          bubble;
    logic          flush;
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] decode_rs_address;
  logic [AW-1:0] decode_rt_address;
  logic          decode_uses_rs;
  logic          decode_uses_rt;
  logic [AW-1:0] execute_rs_address;
  logic [AW-1:0] execute_rt_address;
  logic [AW-1:0] execute_regfile_write_address;
  logic          execute_refile_write_en;
  logic          execute_ram_to_register_en;
  logic          execute_branch_taken;
  logic          multdiv_start;
  logic          multdiv_ready;
  logic          pipeline_stall;
  logic          execute_bubble_en;
  logic          flush_en;
  logic [1:0]    forward_a_select;
  logic [1:0]    forward_b_select;
  logic [CW-1:0] stall_count;
  logic [CW-1:0] flush_count;

  always #5 clock = ~clock;

  hazard_forward_controller #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clock                         (clock),
    .reset                         (reset),
    .decode_rs_address             (decode_rs_address),
    .decode_rt_address             (decode_rt_address),
    .decode_uses_rs                (decode_uses_rs),
    .decode_uses_rt                (decode_uses_rt),
    .execute_rs_address            (execute_rs_address),
    .execute_rt_address            (execute_rt_address),
    .execute_regfile_write_address (execute_regfile_write_address),
    .execute_refile_write_en       (execute_refile_write_en),
    .execute_ram_to_register_en    (execute_ram_to_register_en),
    .execute_branch_taken          (execute_branch_taken),
    .multdiv_start                 (multdiv_start),
    .multdiv_ready                 (multdiv_ready),
    .pipeline_stall                (pipeline_stall),
    .execute_bubble_en             (execute_bubble_en),
    .flush_en                      (flush_en),
    .forward_a_select              (forward_a_select),
    .forward_b_select              (forward_b_select),
    .stall_count                   (stall_count),
    .flush_count                   (flush_count)
  );

  exp_t  sb_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  string phase = "init";

  // Reference state: FSM, shadow X/M and M/W destinations, counters.
  logic [1:0]    m_st;
  logic [AW-1:0] m_mem_a;
  logic          m_mem_we;
  logic          m_mem_ld;
  logic [AW-1:0] m_wb_a;
  logic          m_wb_we;
  logic [CW-1:0] m_sc;
  logic [CW-1:0] m_fc;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got %h expected %h at %0t", phase, tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [AW-1:0] src);
    if (src == 0) return 2'b00;
    if (m_mem_we && !m_mem_ld && m_mem_a == src) return 2'b01;
    if (m_wb_we && m_wb_a == src) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_st = ST_RUN; m_mem_a = '0; m_mem_we = 0; m_mem_ld = 0;
    m_wb_a = '0; m_wb_we = 0; m_sc = '0; m_fc = '0;
  endtask

  task automatic apply(input stim_t s);
    exp_t       e;
    exp_t       p;
    logic [1:0] nst;
    logic       lu;
    @(negedge clock);
    reset                         = s.rst;
    decode_rs_address             = s.d_rs;
    decode_rt_address             = s.d_rt;
    decode_uses_rs                = s.u_rs;
    decode_uses_rt                = s.u_rt;
    execute_rs_address            = s.x_rs;
    execute_rt_address            = s.x_rt;
    execute_regfile_write_address = s.x_dst;
    execute_refile_write_en       = s.x_we;
    execute_ram_to_register_en    = s.x_ld;
    execute_branch_taken          = s.br;
    multdiv_start                 = s.md_start;
    multdiv_ready                 = s.md_ready;
    e   = '0;
    nst = ST_RUN;
    if (!s.rst) begin
      e.fa = ref_fwd(s.x_rs);
      e.fb = ref_fwd(s.x_rt);
      e.sc = m_sc;
      e.fc = m_fc;
      lu = s.x_ld && s.x_we && (s.x_dst != 0) &&
           ((s.u_rs && s.d_rs == s.x_dst) || (s.u_rt && s.d_rt == s.x_dst));
      if (m_st == ST_MD) begin
        e.stall = !s.md_ready;
        nst = s.md_ready ? ST_RUN : ST_MD;
      end else if (m_st == ST_FL) begin
        nst = ST_RUN;
      end else if (s.br) begin
        e.flush = 1'b1;
        nst = ST_FL;
      end else begin
        e.stall  = lu;
        e.bubble = lu;
        nst = (s.md_start && !s.md_ready) ? ST_MD : ST_RUN;
      end
    end
    sb_q.push_back(e);
    #1;
    p = sb_q.pop_front();
    check("stall",     16'(pipeline_stall),    16'(p.stall));
    check("bubble",    16'(execute_bubble_en), 16'(p.bubble));
    check("flush",     16'(flush_en),          16'(p.flush));
    check("fwd_a",     16'(forward_a_select),  16'(p.fa));
    check("fwd_b",     16'(forward_b_select),  16'(p.fb));
    check("stall_cnt", 16'(stall_count),       16'(p.sc));
    check("flush_cnt", 16'(flush_count),       16'(p.fc));
    @(posedge clock);
    if (s.rst) begin
      model_reset();
    end else begin
      if (e.stall && m_sc != '1) m_sc = m_sc + 16'd1;
      if (e.flush && m_fc != '1) m_fc = m_fc + 16'd1;
      if (m_st != ST_MD) begin
        m_wb_a   = m_mem_a;
        m_wb_we  = m_mem_we;
        m_mem_a  = s.x_dst;
        m_mem_we = s.x_we;
        m_mem_ld = s.x_ld;
      end
      m_st = nst;
    end
  endtask

  stim_t s;

  initial begin
    reset = 1'b1;
    model_reset();

    phase = "reset";
    s = '0; s.rst = 1; s.x_ld = 1; s.x_we = 1; s.x_dst = 5'd3; s.d_rs = 5'd3; s.u_rs = 1;
    apply(s);
    s = '0; apply(s);

    phase = "alu_fwd";
    s = '0; s.x_dst = 5'd5; s.x_we = 1; apply(s);
    s = '0; s.x_rs = 5'd5; apply(s);
    s = '0; s.x_rs = 5'd5; apply(s);
    s = '0; s.x_rs = 5'd5; apply(s);

    phase = "load_use";
    s = '0; s.x_dst = 5'd7; s.x_we = 1; s.x_ld = 1; s.d_rt = 5'd7; s.u_rt = 1; apply(s);
    s = '0; s.d_rt = 5'd7; s.u_rt = 1; apply(s);
    s = '0; s.x_rt = 5'd7; apply(s);

    phase = "load_r0";
    s = '0; s.x_dst = 5'd0; s.x_we = 1; s.x_ld = 1; s.u_rs = 1; s.u_rt = 1; apply(s);
    s = '0; apply(s);
    apply(s);

    phase = "multdiv";
    s = '0; s.x_dst = 5'd9; s.x_we = 1; s.md_start = 1; apply(s);
    for (int i = 0; i < 5; i++) begin
      s = '0; s.x_rs = 5'd9; s.x_dst = 5'(i + 11); s.x_we = 1; apply(s);
    end
    s = '0; s.x_rs = 5'd9; s.md_ready = 1; apply(s);
    s = '0; s.x_rs = 5'd9; apply(s);

    phase = "md_ready_same";
    s = '0; s.md_start = 1; s.md_ready = 1; apply(s);
    s = '0; apply(s);

    phase = "branch_lu";
    s = '0; s.br = 1; s.x_dst = 5'd4; s.x_we = 1; s.x_ld = 1; s.d_rs = 5'd4; s.u_rs = 1; apply(s);
    s = '0; s.br = 1; apply(s);
    s = '0; apply(s);

    phase = "reset_md";
    s = '0; s.md_start = 1; apply(s);
    s = '0; apply(s);
    apply(s);
    s = '0; s.rst = 1; apply(s);
    s = '0; apply(s);
    s = '0; s.x_dst = 5'd2; s.x_we = 1; apply(s);
    s = '0; s.x_rs = 5'd2; s.x_rt = 5'd2; apply(s);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      s = '0;
      s.d_rs = 5'($urandom_range(0, 3));
      s.d_rt = 5'($urandom_range(0, 3));
      s.u_rs = 1'($urandom_range(0, 1));
      s.u_rt = 1'($urandom_range(0, 1));
      s.x_rs = 5'($urandom_range(0, 3));
      s.x_rt = 5'($urandom_range(0, 3));
      s.x_dst = 5'($urandom_range(0, 3));
      s.x_we = 1'($urandom_range(0, 1));
      s.x_ld = ($urandom_range(0, 2) == 0);
      s.br = ($urandom_range(0, 7) == 0);
      s.md_start = ($urandom_range(0, 9) == 0);
      s.md_ready = ($urandom_range(0, 2) != 0);
      apply(s);
    end
    s = '0; s.md_ready = 1; apply(s);

    phase = "saturate";
    s = '0; s.md_start = 1; apply(s);
    s = '0;
    for (int i = 0; i < 65540; i++) apply(s);
    s = '0; s.md_ready = 1; apply(s);
    s = '0; apply(s);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_forward_controller.md
Name: hazard_forward_controller

Overview:
- Consumes the execute-stage control fields produced by the decode/execute pipeline latch.
- Decides, each cycle, whether the front of the pipeline advances, stalls, or is flushed.
- Tracks in-flight register writes in the memory and writeback stages with its own shadow pipeline, and generates operand-forwarding selects for the ALU inputs.
- Sits beside the pipeline latches and drives their enables, reset-to-bubble controls, and the execute operand muxes.

Parameters:
- ADDR_W, 5, register-file address width.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- decode_rs_address  input  ADDR_W  source A of the instruction in decode.
- decode_rt_address  input  ADDR_W  source B of the instruction in decode.
- decode_uses_rs  input  1  decode instruction reads rs.
- decode_uses_rt  input  1  decode instruction reads rt.
- execute_rs_address  input  ADDR_W  source A of the instruction in execute.
- execute_rt_address  input  ADDR_W  source B of the instruction in execute.
- execute_regfile_write_address  input  ADDR_W  destination of the execute instruction.
- execute_refile_write_en  input  1  execute instruction writes the register file.
- execute_ram_to_register_en  input  1  execute instruction is a load.
- execute_branch_taken  input  1  branch/jump resolved taken in execute this cycle.
- multdiv_start  input  1  execute instruction starts a multicycle mult/div.
- multdiv_ready  input  1  mult/div result is valid.
- pipeline_stall  output  1  hold PC, F/D and D/X latches.
- execute_bubble_en  output  1  load a NOP into the D/X latch next edge.
- flush_en  output  1  clear the F/D and D/X latches next edge.
- forward_a_select  output  2  00 regfile, 01 memory-stage result, 10 writeback result.
- forward_b_select  output  2  same encoding for operand B.
- stall_count  output  CNT_W  cycles with pipeline_stall=1, saturating.
- flush_count  output  CNT_W  flush events, saturating.

Behaviour:
- Reset:
  - FSM enters RUN.
  - Shadow memory and writeback entries are cleared (write_en=0, addr=0).
  - Both counters are 0.
  - All outputs are 0.
- Shadow pipeline:
  - Each edge where the FSM is not in MD_WAIT, mem entry ← {execute address, write_en, load}.
  - Each such edge, wb entry ← mem entry.
  - In MD_WAIT, both entries hold.
- Forwarding (combinational, per operand X∈{rs,rt} of execute):
  - Select 01 if mem.write_en && mem.addr==X && X!=0 && !mem.load.
  - Else select 10 if wb.write_en && wb.addr==X && X!=0.
  - Else 00.
  - The memory stage wins over writeback when both match.
  - A load in the memory stage is never forwarded from memory; the stall rule guarantees it reaches writeback first.
- Load-use hazard (combinational):
  - Condition: execute_ram_to_register_en && execute_refile_write_en && dest!=0 && ((decode_uses_rs && rs==dest) || (decode_uses_rt && rt==dest)).
  - Response: pipeline_stall=1 and execute_bubble_en=1 for exactly one cycle.
  - The next cycle the load is in the memory stage and the hazard condition is false.
- FSM states RUN, MD_WAIT, FLUSH:
  - RUN → MD_WAIT on multdiv_start && !multdiv_ready.
  - RUN → FLUSH on execute_branch_taken.
  - MD_WAIT: pipeline_stall=1, execute_bubble_en=0 (the execute instruction holds). Exit to RUN in the cycle multdiv_ready=1; stall drops in that same cycle.
  - FLUSH lasts exactly one cycle: flush_en=0, stall=0. Returns to RUN.
- flush_en=1 in the cycle execute_branch_taken=1 while in RUN.
- Priority, highest first:
  1. MD_WAIT stall.
  2. Branch flush. A load-use stall in the same cycle is suppressed, because the decode instruction is killed.
  3. Load-use stall.
- multdiv_start with multdiv_ready=1 in the same cycle: no wait, stay in RUN.
- A taken branch in FLUSH state is ignored; the instruction is a flushed bubble.
- Counters:
  - stall_count increments in each cycle pipeline_stall=1.
  - flush_count increments in each cycle flush_en=1.
  - Both saturate at all-ones and never wrap.
- Reset asserted mid-MD_WAIT or mid-FLUSH: immediate return to RUN; outputs go to 0 asynchronously.

Test Plan:
- ALU writes $5, next instruction reads $5 as rs → cycle after: forward_a_select=01; one further cycle: forward_a_select=10 if $5 is still read; no stall.
- Load to $7 in execute, decode rt=$7 with uses_rt=1 → pipeline_stall=1 and execute_bubble_en=1 for exactly 1 cycle; next cycle forward_b_select=10; stall_count=1.
- Load to $0, decode reads $0 → no stall; forward selects stay 00.
- multdiv_start=1 with multdiv_ready low for 5 cycles → pipeline_stall=1 for exactly 5 cycles; shadow entries hold; stall_count=5.
- Taken branch coinciding with a load-use match → flush_en=1, pipeline_stall=0, flush_count=1; cycle after: state RUN, no flush.
- Reset pulse during MD_WAIT → all outputs 0 immediately; after release, RUN; counters 0. Also force stall_count to 16'hFFFF and stall once more → stays 16'hFFFF.
